// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if: control/status bundle between the LC-3 sequencer and its datapath and memory
interface lc3_control_fsm_if;
  logic        i_run;
  logic [15:0] i_ir;
  logic [2:0]  i_nzp;
  logic        i_mem_ready;
  logic [3:0]  o_state;
  logic        o_ld_mar;
  logic        o_ld_mdr;
  logic        o_ld_ir;
  logic        o_ld_pc;
  logic        o_ld_reg;
  logic        o_ld_cc;
  logic        o_pc_inc;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [1:0]  o_mar_sel;
  logic [1:0]  o_pc_sel;
  logic [1:0]  o_reg_src;
  logic        o_dr_r7;
  logic [1:0]  o_alu_op;
  logic        o_instr_done;
  logic        o_halted;
  logic        o_illegal;
  logic        o_bus_err;
  modport master (
    input  i_run, i_ir, i_nzp, i_mem_ready,
    output o_state, o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_reg, o_ld_cc, o_pc_inc,
           o_mem_en, o_mem_we, o_mar_sel, o_pc_sel, o_reg_src, o_dr_r7, o_alu_op,
           o_instr_done, o_halted, o_illegal, o_bus_err
  );
  modport slave (
    output i_run, i_ir, i_nzp, i_mem_ready,
    input  o_state, o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_reg, o_ld_cc, o_pc_inc,
           o_mem_en, o_mem_we, o_mar_sel, o_pc_sel, o_reg_src, o_dr_r7, o_alu_op,
           o_instr_done, o_halted, o_illegal, o_bus_err
  );
endinterface

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: multicycle fetch/decode/execute sequencer driving the LC-3 datapath strobes
module lc3_control_fsm #(
  parameter int unsigned WAIT_MAX = 255
) (
  input logic clk,
  input logic reset,
  lc3_control_fsm_if.master bus
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FADDR = 4'd1;
  localparam logic [3:0] S_FWAIT = 4'd2;
  localparam logic [3:0] S_DEC   = 4'd3;
  localparam logic [3:0] S_EXEC  = 4'd4;
  localparam logic [3:0] S_MWAIT = 4'd5;
  localparam logic [3:0] S_WB    = 4'd6;
  localparam logic [3:0] S_HALT  = 4'd7;
  localparam logic [15:0] W_LAST = 16'(WAIT_MAX - 1);
  logic [3:0]  r_state;
  logic [15:0] r_wcnt;
  logic        r_halted;
  logic        r_illegal;
  logic        r_bus_err;
  logic [3:0]  w_next;
  logic [3:0]  w_op;
  logic [3:0]  w_after;
  logic        w_store;
  logic        w_mem_op;
  logic        w_illegal_op;
  logic        w_wait;
  logic        w_timeout;
  logic        w_enter_wait;
  logic        w_ld_mar;
  logic        w_ld_mdr;
  logic        w_ld_ir;
  logic        w_ld_pc;
  logic        w_ld_reg;
  logic        w_ld_cc;
  logic        w_pc_inc;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [1:0]  w_mar_sel;
  logic [1:0]  w_pc_sel;
  logic [1:0]  w_reg_src;
  logic        w_dr_r7;
  logic [1:0]  w_alu_op;
  logic        w_done;
  assign w_op         = bus.i_ir[15:12];
  assign w_store      = bus.i_ir[12];
  assign w_mem_op     = !w_op[3] && w_op[1];
  assign w_illegal_op = w_op == 4'b1000 || w_op == 4'b1101 || w_op == 4'b1010 || w_op == 4'b1011;
  assign w_wait       = r_state == S_FWAIT || r_state == S_MWAIT;
  assign w_timeout    = w_wait && !bus.i_mem_ready && r_wcnt == W_LAST;
  assign w_after      = bus.i_run ? S_FADDR : S_IDLE;
  assign w_enter_wait = (w_next == S_FWAIT && r_state != S_FWAIT) || (w_next == S_MWAIT && r_state != S_MWAIT);
  // datapath strobes and selects decoded from the current state, opcode and condition codes
  always_comb begin
    w_ld_mar  = 1'b0;
    w_ld_mdr  = 1'b0;
    w_ld_ir   = 1'b0;
    w_ld_pc   = 1'b0;
    w_ld_reg  = 1'b0;
    w_ld_cc   = 1'b0;
    w_pc_inc  = 1'b0;
    w_mem_en  = 1'b0;
    w_mem_we  = 1'b0;
    w_mar_sel = 2'd0;
    w_pc_sel  = 2'd0;
    w_reg_src = 2'd0;
    w_dr_r7   = 1'b0;
    w_alu_op  = 2'd0;
    w_done    = 1'b0;
    case (r_state)
      S_FADDR: begin
        w_ld_mar = 1'b1;
        w_pc_inc = 1'b1;
      end
      S_FWAIT: begin
        w_mem_en = 1'b1;
        w_ld_ir  = bus.i_mem_ready;
      end
      S_EXEC: begin
        case (w_op)
          4'b0001, 4'b0101, 4'b1001: begin
            w_ld_reg = 1'b1;
            w_ld_cc  = 1'b1;
            w_alu_op = w_op == 4'b0101 ? 2'd1 : w_op == 4'b1001 ? 2'd2 : 2'd0;
            w_done   = 1'b1;
          end
          4'b0000: begin
            w_ld_pc = |(bus.i_ir[11:9] & bus.i_nzp);
            w_done  = 1'b1;
          end
          4'b1100: begin
            w_ld_pc  = 1'b1;
            w_pc_sel = 2'd1;
            w_done   = 1'b1;
          end
          4'b0100: begin
            w_ld_reg  = 1'b1;
            w_reg_src = 2'd2;
            w_dr_r7   = 1'b1;
            w_ld_pc   = 1'b1;
            w_pc_sel  = bus.i_ir[11] ? 2'd2 : 2'd1;
            w_done    = 1'b1;
          end
          4'b1110: begin
            w_ld_reg  = 1'b1;
            w_reg_src = 2'd3;
            w_done    = 1'b1;
          end
          4'b0010, 4'b0011, 4'b0110, 4'b0111: begin
            w_ld_mar  = 1'b1;
            w_mar_sel = bus.i_ir[14] ? 2'd2 : 2'd1;
          end
          default: ;
        endcase
      end
      S_MWAIT: begin
        w_mem_en = 1'b1;
        w_mem_we = w_store;
        w_ld_mdr = bus.i_mem_ready && !w_store;
        w_done   = bus.i_mem_ready && w_store;
      end
      S_WB: begin
        w_ld_reg  = 1'b1;
        w_ld_cc   = 1'b1;
        w_reg_src = 2'd1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end
  // sequencing; memory ready wins over a timeout landing in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.i_run ? S_FADDR : S_IDLE;
      S_FADDR: w_next = S_FWAIT;
      S_FWAIT: w_next = bus.i_mem_ready ? S_DEC : w_timeout ? S_HALT : S_FWAIT;
      S_DEC:   w_next = (w_op == 4'b1111 || w_illegal_op) ? S_HALT : S_EXEC;
      S_EXEC:  w_next = w_done ? w_after : w_mem_op ? S_MWAIT : S_HALT;
      S_MWAIT: w_next = bus.i_mem_ready ? (w_store ? w_after : S_WB) : w_timeout ? S_HALT : S_MWAIT;
      S_WB:    w_next = w_after;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end
  // state, wait counter and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 16'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wcnt    <= w_enter_wait ? 16'd0 : (w_wait && !bus.i_mem_ready) ? r_wcnt + 16'd1 : r_wcnt;
      r_halted  <= r_halted || w_next == S_HALT;
      r_illegal <= r_illegal || (r_state == S_DEC && w_illegal_op);
      r_bus_err <= r_bus_err || w_timeout;
    end
  end
  assign bus.o_state      = r_state;
  assign bus.o_ld_mar     = w_ld_mar;
  assign bus.o_ld_mdr     = w_ld_mdr;
  assign bus.o_ld_ir      = w_ld_ir;
  assign bus.o_ld_pc      = w_ld_pc;
  assign bus.o_ld_reg     = w_ld_reg;
  assign bus.o_ld_cc      = w_ld_cc;
  assign bus.o_pc_inc     = w_pc_inc;
  assign bus.o_mem_en     = w_mem_en;
  assign bus.o_mem_we     = w_mem_we;
  assign bus.o_mar_sel    = w_mar_sel;
  assign bus.o_pc_sel     = w_pc_sel;
  assign bus.o_reg_src    = w_reg_src;
  assign bus.o_dr_r7      = w_dr_r7;
  assign bus.o_alu_op     = w_alu_op;
  assign bus.o_instr_done = w_done;
  assign bus.o_halted     = r_halted;
  assign bus.o_illegal    = r_illegal;
  assign bus.o_bus_err    = r_bus_err;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: table-driven directed check of the LC-3 control sequencer
module tb_lc3_control_fsm;
  localparam logic [18:0] O_MAR  = 19'h40000;
  localparam logic [18:0] O_MDR  = 19'h20000;
  localparam logic [18:0] O_IR   = 19'h10000;
  localparam logic [18:0] O_PC   = 19'h08000;
  localparam logic [18:0] O_REG  = 19'h04000;
  localparam logic [18:0] O_CC   = 19'h02000;
  localparam logic [18:0] O_INC  = 19'h01000;
  localparam logic [18:0] O_MEN  = 19'h00800;
  localparam logic [18:0] O_MWE  = 19'h00400;
  localparam logic [18:0] O_MS1  = 19'h00100;
  localparam logic [18:0] O_MS2  = 19'h00200;
  localparam logic [18:0] O_PS1  = 19'h00040;
  localparam logic [18:0] O_PS2  = 19'h00080;
  localparam logic [18:0] O_RS1  = 19'h00010;
  localparam logic [18:0] O_RS2  = 19'h00020;
  localparam logic [18:0] O_RS3  = 19'h00030;
  localparam logic [18:0] O_R7   = 19'h00008;
  localparam logic [18:0] O_AL1  = 19'h00002;
  localparam logic [18:0] O_AL2  = 19'h00004;
  localparam logic [18:0] O_DONE = 19'h00001;
  localparam logic [18:0] O_NONE = 19'h00000;
  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] out;
    logic [2:0]  flg;
  } vec_t;
  logic clk;
  logic reset;
  int n_cmp;
  int n_bad;
  vec_t v[$];
  logic [18:0] w_out;
  logic [2:0]  w_flg;
  lc3_control_fsm_if bus();
  lc3_control_fsm #(.WAIT_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign w_out = {bus.o_ld_mar, bus.o_ld_mdr, bus.o_ld_ir, bus.o_ld_pc, bus.o_ld_reg, bus.o_ld_cc,
                  bus.o_pc_inc, bus.o_mem_en, bus.o_mem_we, bus.o_mar_sel, bus.o_pc_sel,
                  bus.o_reg_src, bus.o_dr_r7, bus.o_alu_op, bus.o_instr_done};
  assign w_flg = {bus.o_halted, bus.o_illegal, bus.o_bus_err};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic run, input logic [15:0] ir, input logic [2:0] nzp,
                     input logic rdy, input logic [3:0] st, input logic [18:0] out, input logic [2:0] flg);
    vec_t r;
    r.rst = rst; r.run = run; r.ir = ir; r.nzp = nzp; r.rdy = rdy; r.st = st; r.out = out; r.flg = flg;
    v.push_back(r);
  endtask
  task automatic pre(input logic [15:0] ir, input logic [2:0] nzp);
    add(1'b0, 1'b1, ir, nzp, 1'b1, 4'd1, O_MAR | O_INC, 3'b000);
    add(1'b0, 1'b1, ir, nzp, 1'b1, 4'd2, O_MEN | O_IR, 3'b000);
    add(1'b0, 1'b1, ir, nzp, 1'b1, 4'd3, O_NONE, 3'b000);
  endtask
  task automatic latency(input logic [15:0] ir, input logic [2:0] nzp, input int exp, input string nm);
    int cnt;
    logic found;
    cnt = 0;
    found = 1'b0;
    bus.i_ir = ir;
    bus.i_nzp = nzp;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      cnt++;
      if (bus.o_instr_done === 1'b1) found = 1'b1;
      @(posedge clk);
      #1;
    end
    check(nm, 32'(cnt), 32'(exp));
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.i_run = 1'b1;
    bus.i_ir = 16'h1283;
    bus.i_nzp = 3'b000;
    bus.i_mem_ready = 1'b1;
    add(1'b1, 1'b1, 16'h1283, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    pre(16'h1283, 3'b000);
    add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b1, 4'd4, O_REG | O_CC | O_DONE, 3'b000);
    pre(16'h0405, 3'b010);
    add(1'b0, 1'b1, 16'h0405, 3'b010, 1'b1, 4'd4, O_PC | O_DONE, 3'b000);
    pre(16'h0405, 3'b100);
    add(1'b0, 1'b1, 16'h0405, 3'b100, 1'b1, 4'd4, O_DONE, 3'b000);
    pre(16'h5000, 3'b000);
    add(1'b0, 1'b1, 16'h5000, 3'b000, 1'b1, 4'd4, O_REG | O_CC | O_AL1 | O_DONE, 3'b000);
    pre(16'h9000, 3'b000);
    add(1'b0, 1'b1, 16'h9000, 3'b000, 1'b1, 4'd4, O_REG | O_CC | O_AL2 | O_DONE, 3'b000);
    pre(16'hC1C0, 3'b000);
    add(1'b0, 1'b1, 16'hC1C0, 3'b000, 1'b1, 4'd4, O_PC | O_PS1 | O_DONE, 3'b000);
    pre(16'h4800, 3'b000);
    add(1'b0, 1'b1, 16'h4800, 3'b000, 1'b1, 4'd4, O_PC | O_REG | O_RS2 | O_R7 | O_PS2 | O_DONE, 3'b000);
    pre(16'h4080, 3'b000);
    add(1'b0, 1'b1, 16'h4080, 3'b000, 1'b1, 4'd4, O_PC | O_REG | O_RS2 | O_R7 | O_PS1 | O_DONE, 3'b000);
    pre(16'hE000, 3'b000);
    add(1'b0, 1'b1, 16'hE000, 3'b000, 1'b1, 4'd4, O_REG | O_RS3 | O_DONE, 3'b000);
    pre(16'h2203, 3'b000);
    add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b0, 4'd4, O_MAR | O_MS1, 3'b000);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b0, 4'd5, O_MEN, 3'b000);
    add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b1, 4'd5, O_MEN | O_MDR, 3'b000);
    add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b1, 4'd6, O_REG | O_CC | O_RS1 | O_DONE, 3'b000);
    pre(16'h6000, 3'b000);
    add(1'b0, 1'b1, 16'h6000, 3'b000, 1'b1, 4'd4, O_MAR | O_MS2, 3'b000);
    add(1'b0, 1'b1, 16'h6000, 3'b000, 1'b1, 4'd5, O_MEN | O_MDR, 3'b000);
    add(1'b0, 1'b1, 16'h6000, 3'b000, 1'b1, 4'd6, O_REG | O_CC | O_RS1 | O_DONE, 3'b000);
    pre(16'h3000, 3'b000);
    add(1'b0, 1'b1, 16'h3000, 3'b000, 1'b1, 4'd4, O_MAR | O_MS1, 3'b000);
    add(1'b0, 1'b1, 16'h3000, 3'b000, 1'b1, 4'd5, O_MEN | O_MWE | O_DONE, 3'b000);
    add(1'b0, 1'b1, 16'h7441, 3'b000, 1'b1, 4'd1, O_MAR | O_INC, 3'b000);
    add(1'b0, 1'b1, 16'h7441, 3'b000, 1'b1, 4'd2, O_MEN | O_IR, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b1, 4'd3, O_NONE, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b1, 4'd4, O_MAR | O_MS2, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b0, 4'd5, O_MEN | O_MWE, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b1, 4'd5, O_MEN | O_MWE | O_DONE, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    add(1'b0, 1'b0, 16'h7441, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    add(1'b0, 1'b1, 16'hD000, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    pre(16'hD000, 3'b000);
    add(1'b0, 1'b1, 16'hD000, 3'b000, 1'b1, 4'd7, O_NONE, 3'b110);
    add(1'b0, 1'b1, 16'hD000, 3'b000, 1'b1, 4'd7, O_NONE, 3'b110);
    add(1'b1, 1'b1, 16'hF025, 3'b000, 1'b1, 4'd7, O_NONE, 3'b110);
    add(1'b0, 1'b1, 16'hF025, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    pre(16'hF025, 3'b000);
    add(1'b0, 1'b1, 16'hF025, 3'b000, 1'b1, 4'd7, O_NONE, 3'b100);
    add(1'b1, 1'b1, 16'h1283, 3'b000, 1'b0, 4'd7, O_NONE, 3'b100);
    add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b0, 4'd0, O_NONE, 3'b000);
    add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b0, 4'd1, O_MAR | O_INC, 3'b000);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b0, 4'd2, O_MEN, 3'b000);
    add(1'b0, 1'b1, 16'h1283, 3'b000, 1'b1, 4'd7, O_NONE, 3'b101);
    add(1'b1, 1'b1, 16'h2203, 3'b000, 1'b1, 4'd7, O_NONE, 3'b101);
    add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    pre(16'h2203, 3'b000);
    add(1'b0, 1'b1, 16'h2203, 3'b000, 1'b0, 4'd4, O_MAR | O_MS1, 3'b000);
    add(1'b1, 1'b1, 16'h2203, 3'b000, 1'b0, 4'd5, O_MEN, 3'b000);
    add(1'b0, 1'b0, 16'h2203, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    add(1'b0, 1'b0, 16'h2203, 3'b000, 1'b1, 4'd0, O_NONE, 3'b000);
    @(posedge clk);
    #1;
    foreach (v[i]) begin
      reset = v[i].rst;
      bus.i_run = v[i].run;
      bus.i_ir = v[i].ir;
      bus.i_nzp = v[i].nzp;
      bus.i_mem_ready = v[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d state", i), 32'(bus.o_state), 32'(v[i].st));
      check($sformatf("row%0d strobes", i), 32'(w_out), 32'(v[i].out));
      check($sformatf("row%0d flags", i), 32'(w_flg), 32'(v[i].flg));
      @(posedge clk);
      #1;
    end
    bus.i_run = 1'b1;
    bus.i_mem_ready = 1'b1;
    @(posedge clk);
    #1;
    latency(16'h2000, 3'b000, 6, "lat_ld");
    latency(16'h3000, 3'b000, 5, "lat_st");
    latency(16'h1283, 3'b000, 4, "lat_add");
    latency(16'h0E00, 3'b001, 4, "lat_br");
    latency(16'hE000, 3'b000, 4, "lat_lea");
    bus.i_run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Multicycle control sequencer for the LC-3 CPU datapath. It fetches each instruction from memory through a MAR/MDR-style ready handshake, decodes the IR the datapath loads, and drives the datapath load strobes and mux selects state by state. It also steps the ALU and register file for each instruction class. It sits beside `lc3_cpu`, replacing the bench-driven `IR` stimulus with real fetch/decode/execute sequencing.

## Interface
- `WAIT_MAX`, 255: maximum cycles spent in a memory wait state before a bus error (1..65535).
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; permits starting a new instruction.
- `ir`  in  16  current IR contents from datapath; stable from the `ld_ir` edge onward.
- `nzp`  in  3  datapath condition codes {N,Z,P}.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `state`  out  4  current state encoding (debug).
- `ld_mar`, `ld_mdr`, `ld_ir`, `ld_pc`, `ld_reg`, `ld_cc`, `pc_inc`  out  1 each  datapath load strobes.
- `mem_en`, `mem_we`  out  1 each  memory request / write qualifier.
- `mar_sel`  out  2  0=PC, 1=PC+off9, 2=BaseR+off6.
- `pc_sel`  out  2  0=PC+off9, 1=BaseR, 2=PC+off11.
- `reg_src`  out  2  0=ALU, 1=MDR, 2=PC (link), 3=PC+off9 (LEA).
- `dr_r7`  out  1  force destination register to R7.
- `alu_op`  out  2  0=ADD, 1=AND, 2=NOT, 3=PASS.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `halted`, `illegal`, `bus_err`  out  1 each  sticky status flags.

## Operation
- States: IDLE(0), FETCH_ADDR(1), FETCH_WAIT(2), DECODE(3), EXEC(4), MEM_WAIT(5), WB(6), HALT(7).
- IDLE: no strobes. Goes to FETCH_ADDR when `run`=1.
- FETCH_ADDR: `ld_mar`=1, `mar_sel`=0, `pc_inc`=1. Goes to FETCH_WAIT.
- FETCH_WAIT: `mem_en`=1, `mem_we`=0. When `mem_ready`=1: `ld_ir`=1, then DECODE.
- DECODE: no strobes. Dispatches on `ir[15:12]`:
  - TRAP (1111) goes to HALT and sets `halted`.
  - RTI, reserved, LDI and STI (1000, 1101, 1010, 1011) go to HALT and set `illegal` and `halted`.
  - All other opcodes go to EXEC.
- EXEC outputs per opcode:
  - ADD/AND/NOT (0001/0101/1001): `ld_reg`, `ld_cc`, `reg_src`=0, `alu_op`=0/1/2, `instr_done`.
  - BR (0000): `ld_pc`=1 only if `(ir[11:9] & nzp)`≠0; `pc_sel`=0; `instr_done`.
  - JMP (1100): `ld_pc`, `pc_sel`=1, `instr_done`.
  - JSR/JSRR (0100): `ld_reg`, `reg_src`=2, `dr_r7`, `ld_pc`, `pc_sel`=2 if `ir[11]` else 1, `instr_done`. The link captures the pre-update PC because both loads occur on the same edge.
  - LEA (1110): `ld_reg`, `reg_src`=3, no `ld_cc`, `instr_done`.
  - LD/ST (0010/0011): `ld_mar`, `mar_sel`=1, then MEM_WAIT.
  - LDR/STR (0110/0111): `ld_mar`, `mar_sel`=2, then MEM_WAIT.
- MEM_WAIT: `mem_en`=1, `mem_we`=1 for stores. On `mem_ready`:
  - loads assert `ld_mdr` and go to WB;
  - stores assert `instr_done` and continue.
- WB: `ld_reg`, `ld_cc`, `reg_src`=1, `instr_done`.
- After any `instr_done`, the next state is FETCH_ADDR if `run`=1, else IDLE.
- Wait counter: 16-bit, cleared on entry to FETCH_WAIT or MEM_WAIT, increments each wait cycle without `mem_ready`. When it reaches `WAIT_MAX` without `mem_ready`, go to HALT and set `bus_err` and `halted`.
- HALT: absorbing; all strobes 0. Exited only by `reset`.

## Timing
- Reset: state=IDLE, all strobes and selects 0, `halted`=`illegal`=`bus_err`=0, wait counter 0. Reset applied mid-instruction aborts it on that edge with no further strobes.
- Strobes and selects are combinational from (state, `ir`, `nzp`, `mem_ready`). Flags and state are registered.
- Latency with zero-wait memory (`mem_ready` high on the first wait cycle), counted FETCH_ADDR to `instr_done` inclusive:
  - operate, BR, JMP, JSR, LEA: 4 cycles;
  - ST/STR: 5 cycles;
  - LD/LDR: 6 cycles.
- Each extra memory wait cycle adds 1.
- `mem_ready` is ignored outside the wait states.
- `run` dropping mid-instruction does not abort it; the instruction completes, then the block enters IDLE.
- `mem_ready` arriving in the same cycle the counter reaches `WAIT_MAX` counts as success, not an error.

## Test plan
- Reset held 2 cycles with `run`=1 -> state=0 and all outputs 0. After release, state=1 on the next edge.
- Operate: `ir`=16'h1283 (ADD), `mem_ready` always 1 -> states 1,2,3,4. In EXEC, `ld_reg`=`ld_cc`=1, `alu_op`=0, `instr_done`=1. State=1 on the following edge.
- Branch: `ir`=16'h0405 (BRz). With `nzp`=3'b010, `ld_pc`=1 in EXEC; with `nzp`=3'b100, `ld_pc`=0. Both complete in 4 cycles.
- Load with waits: `ir`=16'h2203, `mem_ready` low for 3 cycles in MEM_WAIT -> `ld_mdr` pulses once, then WB with `reg_src`=1. Total 9 cycles.
- Errors:
  - `ir`=16'hD000 -> HALT with `illegal`=`halted`=1; the block stays halted with `run`=1 until reset.
  - With `WAIT_MAX`=4 and `mem_ready` stuck at 0 in FETCH_WAIT -> `bus_err`=1 after 4 wait cycles.
- Store then `run`=0: `ir`=16'h7441 (STR) -> `mem_we`=1 while in MEM_WAIT, `instr_done` on `mem_ready`, then IDLE with no further `mem_en`.
